// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding
// and load-use hazard detection for the execute stage.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_id_valid,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic [4:0]      i_id_rd,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [1:0]      i_id_src_a,
    input  logic            i_id_src_b,
    input  logic [1:0]      i_id_op_class,
    input  logic [2:0]      i_id_funct3,
    input  logic            i_id_funct7b5,
    input  logic            i_id_regwrite,
    input  logic            i_id_memread,
    input  logic            i_id_memwrite,
    input  logic [4:0]      i_exmem_rd,
    input  logic            i_exmem_regwrite,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic [4:0]      i_memwb_rd,
    input  logic            i_memwb_regwrite,
    input  logic [XLEN-1:0] i_memwb_result,
    output logic [XLEN-1:0] o_alu_da,
    output logic [XLEN-1:0] o_alu_db,
    output logic [3:0]      o_alu_ctl,
    output logic            o_ex_valid,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_regwrite,
    output logic            o_ex_memread,
    output logic            o_ex_memwrite,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_store_data,
    output logic            o_load_use
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [1:0]      src_a;
        logic            src_b;
        logic [3:0]      alu_ctl;
    } id_ex_t;

    id_ex_t          r_q;
    id_ex_t          w_d;
    logic [3:0]      w_alu_ctl;
    logic [3:0]      w_f3_ctl;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;

    always_comb begin
        w_f3_ctl = 4'b0000;
        case (i_id_funct3)
            3'b000:  w_f3_ctl = (i_id_op_class == 2'b01 && i_id_funct7b5)
                                ? 4'b0010 : 4'b0000;
            3'b001:  w_f3_ctl = 4'b1100;
            3'b010:  w_f3_ctl = 4'b1001;
            3'b011:  w_f3_ctl = 4'b1000;
            3'b100:  w_f3_ctl = 4'b0110;
            3'b101:  w_f3_ctl = i_id_funct7b5 ? 4'b1110 : 4'b1101;
            3'b110:  w_f3_ctl = 4'b0101;
            default: w_f3_ctl = 4'b0100;
        endcase
    end

    // Branch compares: beq/bne subtract, blt/bge signed, bltu/bgeu unsigned.
    always_comb begin
        w_alu_ctl = 4'b0000;
        unique case (1'b1)
            (i_id_op_class == 2'b00): w_alu_ctl = 4'b0000;
            (i_id_op_class == 2'b11): begin
                case (i_id_funct3[2:1])
                    2'b10:   w_alu_ctl = 4'b1001;
                    2'b11:   w_alu_ctl = 4'b1000;
                    default: w_alu_ctl = 4'b0010;
                endcase
            end
            default: w_alu_ctl = w_f3_ctl;
        endcase
    end

    always_comb begin
        w_d          = '0;
        w_d.valid    = i_id_valid;
        w_d.regwrite = i_id_valid & i_id_regwrite;
        w_d.memread  = i_id_valid & i_id_memread;
        w_d.memwrite = i_id_valid & i_id_memwrite;
        w_d.pc       = i_id_pc;
        w_d.rs1_data = i_id_rs1_data;
        w_d.rs2_data = i_id_rs2_data;
        w_d.imm      = i_id_imm;
        w_d.rs1      = i_id_rs1;
        w_d.rs2      = i_id_rs2;
        w_d.rd       = i_id_rd;
        w_d.src_a    = i_id_src_a;
        w_d.src_b    = i_id_src_b;
        w_d.alu_ctl  = w_alu_ctl;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (!i_stall) begin
            r_q <= w_d;
        end
    end

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rdata,
        input logic [4:0]      em_rd,
        input logic            em_we,
        input logic [XLEN-1:0] em_res,
        input logic [4:0]      mw_rd,
        input logic            mw_we,
        input logic [XLEN-1:0] mw_res
    );
        if (em_we && em_rd != 5'd0 && em_rd == rs)
            return em_res;
        else if (mw_we && mw_rd != 5'd0 && mw_rd == rs)
            return mw_res;
        else
            return rdata;
    endfunction

    always_comb begin
        w_fwd_a = fwd(r_q.rs1, r_q.rs1_data,
                      i_exmem_rd, i_exmem_regwrite, i_exmem_result,
                      i_memwb_rd, i_memwb_regwrite, i_memwb_result);
        w_fwd_b = fwd(r_q.rs2, r_q.rs2_data,
                      i_exmem_rd, i_exmem_regwrite, i_exmem_result,
                      i_memwb_rd, i_memwb_regwrite, i_memwb_result);
    end

    always_comb begin
        o_alu_da = '0;
        unique case (1'b1)
            (r_q.src_a == 2'b00): o_alu_da = w_fwd_a;
            (r_q.src_a == 2'b01): o_alu_da = r_q.pc;
            default:              o_alu_da = '0;
        endcase
    end

    assign o_alu_db        = r_q.src_b ? r_q.imm : w_fwd_b;
    assign o_alu_ctl       = r_q.alu_ctl;
    assign o_ex_valid      = r_q.valid;
    assign o_ex_rd         = r_q.rd;
    assign o_ex_regwrite   = r_q.regwrite;
    assign o_ex_memread    = r_q.memread;
    assign o_ex_memwrite   = r_q.memwrite;
    assign o_ex_pc         = r_q.pc;
    assign o_ex_store_data = w_fwd_b;

    assign o_load_use = r_q.valid & r_q.memread & (r_q.rd != 5'd0)
                      & ((r_q.rd == i_id_rs1) | (r_q.rd == i_id_rs2));

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the execute-stage ALU. It registers decoded instruction fields at the ID/EX boundary and generates the 4-bit ALU control code from class/funct fields. It resolves EX/MEM and MEM/WB operand forwarding, presents `alu_da`, `alu_db` and `alu_ctl` to the ALU, and flags load-use hazards back to the hazard/stall logic.

## Interface
- `XLEN`, 32, datapath width; the ALU is fixed at 32.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock domain only.
- `stall`  in  1  hold all registered state.
- `flush`  in  1  load a bubble into the stage.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  32  instruction PC.
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_imm`  in  32  sign-extended immediate.
- `id_src_a`  in  2  A select: 00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero).
- `id_src_b`  in  1  B select: 0 rs2, 1 imm.
- `id_op_class`  in  2  00 address/add, 01 R-type, 10 I-type ALU, 11 branch compare.
- `id_funct3`  in  3  instruction funct3.
- `id_funct7b5`  in  1  instruction bit 30.
- `id_regwrite`, `id_memread`, `id_memwrite`  in  1 each  control bits.
- `exmem_rd`, `exmem_regwrite`, `exmem_result`  in  5, 1, 32  EX/MEM forward source.
- `memwb_rd`, `memwb_regwrite`, `memwb_result`  in  5, 1, 32  MEM/WB forward source.
- `alu_da`, `alu_db`  out  32 each  ALU operands.
- `alu_ctl`  out  4  ALU control code.
- `ex_valid`, `ex_rd`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_pc`  out  registered fields.
- `ex_store_data`  out  32  forwarded rs2, used by stores.
- `load_use`  out  1  combinational hazard flag.

## Operation
- Registered fields are pc, rs1/rs2 data, rs1/rs2/rd indices, imm, src_a, src_b, alu_ctl, valid, regwrite, memread and memwrite.
- Update on each rising edge:
  - `flush`=1: load a bubble. All control bits are 0, alu_ctl=0000, and the data fields hold 0. Flush overrides stall.
  - Else `stall`=1: hold every field.
  - Else: capture the ID inputs.
  - Whenever `id_valid`=0, regwrite, memread and memwrite are captured as 0.
- ALU control decode happens before the register.
  - Class 00 gives 0000.
  - Classes 01 and 10 decode funct3:
    - 000: 0000, or 0010 when class 01 and funct7b5=1.
    - 001: 1100.
    - 010: 1001.
    - 011: 1000.
    - 100: 0110.
    - 101: 1101, or 1110 when funct7b5=1 (both classes).
    - 110: 0101.
    - 111: 0100.
  - Class 11 decodes funct3: 000/001 give 0010, 100/101 give 1001, 110/111 give 1000, and 010/011 give 0010.
  - Codes 0001, 0011, 0111 and 1111 are never produced, so ALU overflow reporting stays disabled.
- Forwarding is combinational from the registered indices, applied to each of rs1 and rs2 independently:
  - If `exmem_regwrite` and `exmem_rd`≠0 and `exmem_rd`==rs, use `exmem_result`.
  - Else if `memwb_regwrite` and `memwb_rd`≠0 and `memwb_rd`==rs, use `memwb_result`.
  - Else use the registered data. EX/MEM always wins over MEM/WB.
  - Index 0 never forwards.
- Operand selection:
  - `alu_da` is chosen by src_a: forwarded rs1, pc, or 0.
  - `alu_db` is imm when src_b=1, otherwise forwarded rs2. Shift amounts are taken by the ALU from `alu_db[4:0]`.
  - `ex_store_data` is always forwarded rs2.
- `load_use` = `ex_valid` & `ex_memread` & (`ex_rd`≠0) & ((`ex_rd`==`id_rs1`) | (`ex_rd`==`id_rs2`)).
  - The upstream logic responds by stalling IF/ID and asserting `flush` to this stage in the same cycle.

## Timing
- On `rst_n` low, immediately (asynchronously) and while held:
  - All registered fields go to 0, so `ex_valid`=0 and `alu_ctl`=0000.
  - `alu_da`=0 and `alu_db`=0, provided no forwarding source is active.
- Latency: ID inputs present at edge N appear on the `ex_*` outputs after edge N; they become `alu_ctl` and the ALU operands within the same cycle N+1.
- Forward and operand paths have zero-cycle latency. They are purely combinational after the register, with no added flop.
- Flush and stall asserted together on one edge: a bubble is loaded.
- Release of reset mid-stream: the first edge with `rst_n` high captures normally.
- A stall held for K cycles keeps the outputs stable, except that forwarded operands still track changes on `exmem_*` and `memwb_*`.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle -> all outputs read 0 before the next edge, and `alu_ctl`=0000.
- R-type sub: rs1=5 (data 10), rs2=6 (data 3), funct7b5=1, funct3=000, no forwarding -> the next cycle shows `alu_ctl`=0010, `alu_da`=10, `alu_db`=3.
- Forward priority: registered rs1=7; `exmem_rd`=7 with result 0xAAAA and `memwb_rd`=7 with result 0x5555, both regwrite=1 -> `alu_da`=0xAAAA. Dropping exmem_regwrite -> 0x5555. With rs1=0 -> registered data, never forwarded.
- I-type srai: funct3=101, funct7b5=1, imm=4, src_b=1 -> `alu_ctl`=1110, `alu_db`=4.
- Load-use: EX holds a load with rd=9; ID presents rs2=9 -> `load_use`=1. Asserting `flush` -> the next cycle has `ex_valid`=0 and `ex_regwrite`=0.
- Stall/flush collision: stall=1 and flush=1 on the same edge -> a bubble is loaded. Stall alone for 3 cycles -> the `ex_*` fields are unchanged.
